l2_cache_assoc: RTL and testbench
=================================

# l2_cache_assoc

Parametrised, set-associative, write-through L2 cache between the L1 caches and L3 memory. It is the synchronous successor of the direct-mapped L2. It adds configurable geometry, a valid/ready request handshake, true single-cycle read hits, LRU/round-robin replacement, correct write-hit update and asynchronous reset. A read miss fetches a two-line block from L3 through the existing `L3_*` handshake and returns the addressed line to L1.

## Interface
- `ADDR_W`, 32, address width
- `LINE_W`, 512, bits per line returned on `data`; must be a multiple of 32
- `SUB_LINES`, 2, lines per L3 fill block (power of 2)
- `SETS`, 64, number of sets (power of 2)
- `WAYS`, 2, associativity (power of 2, 1..8)
- Derived: `OFF_W`=log2(LINE_W/8), `SUB_W`=log2(SUB_LINES), `IDX_W`=log2(SETS), `TAG_W`=ADDR_W-OFF_W-SUB_W-IDX_W
- Address split: byte offset `addr[OFF_W-1:0]`, sub-line select next `SUB_W` bits, index next `IDX_W` bits, tag in the remaining high bits

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `renable` in 1: request valid (read, or write when `wenable`=1)
- `wenable` in 1: request is a 32-bit write
- `addr` in ADDR_W: request address
- `wdata` in 32: write data
- `cache_stall` out 1: not ready; request accepted only when 0
- `data` out [0:LINE_W-1]: read line, registered
- `data_valid` out 1: one-cycle pulse, `data` holds a read result
- `L3_addr` out ADDR_W: L3 address
- `L3_wdata` out 32: L3 write data
- `L3_renable` out 1: L3 transaction request (reads and writes)
- `L3_wenable` out 1: transaction is a write
- `L3_stall` in 1: L3 busy; transaction completes on an edge with request high and `L3_stall`=0
- `L2_block` in [0:SUB_LINES*LINE_W-1]: fill data, valid in completion cycle

## Operation
- Storage per set/way: valid bit, tag, fill block. Per set: replacement state. Only valid bits and replacement state are reset.
- Bit order is MSB-first: byte b of a line is `[8b +: 8]`. A write word lands at `[8*(addr[OFF_W-1:2]*4) +: 32]`; `addr[1:0]` is ignored.
- Sub-line s of the fill is `L2_block[s*LINE_W +: LINE_W]`.
- Acceptance: a request is accepted on a rising edge with `renable`=1 and `cache_stall`=0. `cache_stall` = (state != IDLE).
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, read hit: `data` is loaded with the hit way's addressed sub-line and `data_valid` is set to 1. State stays IDLE and the replacement state is updated.
- IDLE, read miss: latch `L3_addr` = addr with the low OFF_W+SUB_W bits cleared, set `L3_renable`=1 and `L3_wenable`=0, then go to RD_MISS.
- IDLE, write: latch `L3_addr`=addr and `L3_wdata`=wdata, set `L3_renable`=1 and `L3_wenable`=1, then go to WR_THRU. On a tag hit the word is updated in the hit way at the same edge. There is no allocate on a write miss.
- RD_MISS completion: choose the victim way as the lowest-index invalid way, otherwise the replacement choice. Write tag, valid and block to the victim way. Load `data` with the addressed sub-line, pulse `data_valid`, drop the L3 enables, return to IDLE.
- WR_THRU completion: drop the L3 enables and return to IDLE. `data_valid` is not pulsed.
- Replacement: WAYS=2 uses true LRU (one bit per set, updated on hit and fill). WAYS>2 uses a per-set round-robin pointer that advances on each fill that evicts a valid line. WAYS=1 has no replacement state.
- `data_valid` clears on every edge where it is not being set.

## Timing
- Reset values (async, immediate): state IDLE, `cache_stall`=0, `data`=0, `data_valid`=0, `L3_addr`=0, `L3_wdata`=0, `L3_renable`=0, `L3_wenable`=0, all valid bits 0, replacement state 0.
- Read hit accepted at edge N: `data`/`data_valid` are seen after N. Back-to-back hits sustain 1 request per cycle.
- Read miss accepted at edge N: `cache_stall`=1 and `L3_renable`=1 after N. If completion occurs at edge M>N, `data_valid` is seen after M and `cache_stall` returns to 0. The minimum miss latency is 2 edges.
- The L3 request and address are held stable from the cycle after acceptance until completion. `L2_block` is sampled only at the completion edge.
- `wenable` without `renable` is ignored. Inputs change while stalled are ignored.
- Reset mid-transaction: the transaction is abandoned and no `data_valid` is produced. Any partial fill is lost because the valid bits are cleared. L3 must tolerate the request dropping.

## Test plan
- Reset, then read 0x0000_8040 (miss), `L3_stall`=1 for 10 cycles, `L2_block` = sub-line 0 all 0xAA and sub-line 1 all 0x55 -> `cache_stall` high 11 cycles, `data`=all 0x55 with one `data_valid` pulse, L3_addr=0x0000_8000.
- Same line read again, then read 0x0000_8000 -> both are hits, `L3_renable` stays 0, `data` = 0x55 pattern then 0xAA pattern, one cycle each.
- Write 0xDEADBEEF to 0x0000_8044 (hit), then read 0x0000_8040 -> L3 write with L3_addr=0x0000_8044, `L3_wenable`=1; the read hit returns bits [32:63]=0xDEADBEEF with the rest 0x55.
- WAYS=2: read tags A, B, A, C on the same index -> C evicts B (LRU); a re-read of A hits and a re-read of B misses.
- Write miss to an uncached address, then read it -> the write does not allocate and the read misses.
- Assert `rst_n`=0 during RD_MISS -> the L3 enables and `cache_stall` are 0 immediately, no `data_valid`, and the previously cached line now misses.

Source files
------------

// File: rtl/l2_cache_assoc.sv
// Set-associative write-through L2: single-cycle read hits, two-line block fills from L3 on read miss,
// write-through with in-place word update on hit and no allocate on write miss.
module l2_cache_assoc #(
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 512,
   parameter int SUB_LINES = 2,
   parameter int SETS      = 64,
   parameter int WAYS      = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          renable,
   input  logic                          wenable,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [31:0]                   wdata,
   output logic                          cache_stall,
   output logic [0:LINE_W-1]             data,
   output logic                          data_valid,
   output logic [ADDR_W-1:0]             L3_addr,
   output logic [31:0]                   L3_wdata,
   output logic                          L3_renable,
   output logic                          L3_wenable,
   input  logic                          L3_stall,
   input  logic [0:SUB_LINES*LINE_W-1]   L2_block
);
   localparam int OFF_W  = $clog2(LINE_W/8);
   localparam int SUB_W  = $clog2(SUB_LINES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF_W - SUB_W - IDX_W;
   localparam int SUB_WI = (SUB_W > 0) ? SUB_W : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << (OFF_W + SUB_W)) - ADDR_W'(1));

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
   state_t state, state_nxt;

   logic [0:SUB_LINES*LINE_W-1] blk_mem [SETS][WAYS];
   logic [TAG_W-1:0]            tag_mem [SETS][WAYS];
   logic [SETS-1:0][WAYS-1:0]   valid;
   logic [SETS-1:0][WAY_W-1:0]  rep;
   logic [SUB_WI-1:0]           miss_sub;

   logic [SUB_WI-1:0]  req_sub;
   logic [IDX_W-1:0]   req_idx, fill_idx;
   logic [TAG_W-1:0]   req_tag, fill_tag;
   logic [OFF_W-3:0]   req_word;
   logic               hit, vic_found, fill_done;
   logic [WAY_W-1:0]   hit_way, victim;

   assign req_sub  = SUB_WI'((addr >> OFF_W) & ADDR_W'(SUB_LINES - 1));
   assign req_idx  = IDX_W'(addr >> (OFF_W + SUB_W));
   assign req_tag  = TAG_W'(addr >> (OFF_W + SUB_W + IDX_W));
   assign req_word = addr[OFF_W-1:2];
   assign fill_idx = IDX_W'(L3_addr >> (OFF_W + SUB_W));
   assign fill_tag = TAG_W'(L3_addr >> (OFF_W + SUB_W + IDX_W));

   assign cache_stall = (state != IDLE);
   assign fill_done   = (state == RD_MISS) && !L3_stall;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Empty ways are always filled first; only a full set consults the replacement state.
   always_comb begin
      vic_found = 1'b0;
      victim    = (WAYS > 1) ? rep[fill_idx] : '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!vic_found && !valid[fill_idx][w]) begin
            vic_found = 1'b1;
            victim    = WAY_W'(w);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (renable) state_nxt = wenable ? WR_THRU : (hit ? IDLE : RD_MISS);
         RD_MISS: if (!L3_stall) state_nxt = IDLE;
         WR_THRU: if (!L3_stall) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data       <= '0;
         data_valid <= 1'b0;
         L3_addr    <= '0;
         L3_wdata   <= '0;
         L3_renable <= 1'b0;
         L3_wenable <= 1'b0;
         valid      <= '0;
         rep        <= '0;
         miss_sub   <= '0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (renable) begin
                  if (wenable) begin
                     L3_addr    <= addr;
                     L3_wdata   <= wdata;
                     L3_renable <= 1'b1;
                     L3_wenable <= 1'b1;
                  end else if (hit) begin
                     data       <= blk_mem[req_idx][hit_way][req_sub*LINE_W +: LINE_W];
                     data_valid <= 1'b1;
                     if (WAYS == 2) rep[req_idx] <= ~hit_way;
                  end else begin
                     L3_addr    <= addr & BLK_MASK;
                     L3_renable <= 1'b1;
                     L3_wenable <= 1'b0;
                     miss_sub   <= req_sub;
                  end
               end
            end
            RD_MISS: begin
               if (!L3_stall) begin
                  valid[fill_idx][victim] <= 1'b1;
                  data       <= L2_block[miss_sub*LINE_W +: LINE_W];
                  data_valid <= 1'b1;
                  L3_renable <= 1'b0;
                  L3_wenable <= 1'b0;
                  // LRU bit names the way to evict next; the pointer only moves past real evictions.
                  if (WAYS == 2)
                     rep[fill_idx] <= ~victim;
                  else if (WAYS > 2 && !vic_found)
                     rep[fill_idx] <= rep[fill_idx] + WAY_W'(1);
               end
            end
            WR_THRU: begin
               if (!L3_stall) begin
                  L3_renable <= 1'b0;
                  L3_wenable <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && renable && wenable && hit)
         blk_mem[req_idx][hit_way][req_sub*LINE_W + req_word*32 +: 32] <= wdata;
      if (fill_done) begin
         blk_mem[fill_idx][victim] <= L2_block;
         tag_mem[fill_idx][victim] <= fill_tag;
      end
   end
endmodule

// File: tb/tb_l2_cache_assoc.sv
// Directed bench for l2_cache_assoc: miss fill, hits, write-through, LRU, write no-allocate, mid-miss reset.
module tb_l2_cache_assoc;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          renable = 1'b0, wenable = 1'b0;
   logic [31:0]   addr = '0, wdata = '0;
   logic          cache_stall;
   logic [0:511]  data;
   logic          data_valid;
   logic [31:0]   L3_addr, L3_wdata;
   logic          L3_renable, L3_wenable;
   logic          L3_stall = 1'b1;
   logic [0:1023] L2_block = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   l2_cache_assoc dut (
      .clk(clk), .rst_n(rst_n), .renable(renable), .wenable(wenable), .addr(addr), .wdata(wdata),
      .cache_stall(cache_stall), .data(data), .data_valid(data_valid),
      .L3_addr(L3_addr), .L3_wdata(L3_wdata), .L3_renable(L3_renable), .L3_wenable(L3_wenable),
      .L3_stall(L3_stall), .L2_block(L2_block)
   );

   function automatic logic [0:511] line_of(input logic [7:0] b);
      return {64{b}};
   endfunction

   function automatic logic [0:1023] blk_of(input logic [7:0] b0, input logic [7:0] b1);
      return {line_of(b0), line_of(b1)};
   endfunction

   // Issues one read with L3 answering immediately; reports whether it missed and the returned line.
   task automatic do_read(input logic [31:0] a, input logic [0:1023] blk,
                          output logic miss, output logic [0:511] d, output logic ok);
      @(negedge clk);
      renable = 1'b1; wenable = 1'b0; addr = a; L2_block = blk; L3_stall = 1'b0;
      @(posedge clk); @(negedge clk);
      renable = 1'b0;
      miss = cache_stall;
      ok = 1'b0;
      d = '0;
      for (int k = 0; k < 20; k++) begin
         if (data_valid) begin
            ok = 1'b1;
            d = data;
            break;
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (cache_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cache_stall); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", data_valid); end
      checks++; if ({L3_renable, L3_wenable} !== 2'b00) begin errors++; $display("FAIL reset_l3en: got %b want 00", {L3_renable, L3_wenable}); end
      checks++; if (L3_addr !== 32'h0 || L3_wdata !== 32'h0) begin errors++; $display("FAIL reset_l3: addr %h wdata %h want 0", L3_addr, L3_wdata); end
      checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read_miss();
      int stall_cyc;
      int dv_cnt;
      @(negedge clk);
      renable = 1'b1; wenable = 1'b0; addr = 32'h0000_8040; L3_stall = 1'b1; L2_block = blk_of(8'hAA, 8'h55);
      @(posedge clk); @(negedge clk);
      renable = 1'b0;
      checks++; if (L3_renable !== 1'b1 || L3_wenable !== 1'b0) begin errors++; $display("FAIL miss_l3en: got %b%b want 10", L3_renable, L3_wenable); end
      checks++; if (L3_addr !== 32'h0000_8000) begin errors++; $display("FAIL miss_l3addr: got %h want 00008000", L3_addr); end
      stall_cyc = cache_stall ? 1 : 0;
      dv_cnt = data_valid ? 1 : 0;
      repeat (10) begin
         @(posedge clk); @(negedge clk);
         if (cache_stall) stall_cyc++;
         if (data_valid) dv_cnt++;
      end
      L3_stall = 1'b0;
      @(posedge clk); @(negedge clk);
      L3_stall = 1'b1;
      checks++; if (stall_cyc != 11) begin errors++; $display("FAIL miss_stall_cycles: got %0d want 11", stall_cyc); end
      checks++; if (dv_cnt != 0) begin errors++; $display("FAIL miss_early_dv: got %0d pulses want 0", dv_cnt); end
      checks++; if (data_valid !== 1'b1 || cache_stall !== 1'b0) begin errors++; $display("FAIL miss_done: dv %b stall %b want 1 0", data_valid, cache_stall); end
      checks++; if (data !== line_of(8'h55)) begin errors++; $display("FAIL miss_data: got %h want all 55", data); end
      checks++; if (L3_renable !== 1'b0) begin errors++; $display("FAIL miss_l3drop: got %b want 0", L3_renable); end
      @(posedge clk); @(negedge clk);
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL miss_dv_pulse: got %b want 0", data_valid); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      renable = 1'b1; wenable = 1'b0; addr = 32'h0000_8040; L2_block = '0;
      @(posedge clk); @(negedge clk);
      addr = 32'h0000_8000;
      checks++; if (data_valid !== 1'b1 || data !== line_of(8'h55)) begin errors++; $display("FAIL hit1: dv %b data %h want 1 all 55", data_valid, data); end
      checks++; if (L3_renable !== 1'b0 || cache_stall !== 1'b0) begin errors++; $display("FAIL hit1_l3: l3en %b stall %b want 0 0", L3_renable, cache_stall); end
      @(posedge clk); @(negedge clk);
      renable = 1'b0;
      checks++; if (data_valid !== 1'b1 || data !== line_of(8'hAA)) begin errors++; $display("FAIL hit2: dv %b data %h want 1 all aa", data_valid, data); end
      checks++; if (L3_renable !== 1'b0) begin errors++; $display("FAIL hit2_l3: got %b want 0", L3_renable); end
      @(posedge clk); @(negedge clk);
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL hit_dv_clear: got %b want 0", data_valid); end
   endtask

   task automatic test_write_hit();
      logic miss, ok;
      logic [0:511] d, exp_line;
      @(negedge clk);
      renable = 1'b1; wenable = 1'b1; addr = 32'h0000_8044; wdata = 32'hDEAD_BEEF; L3_stall = 1'b1;
      @(posedge clk); @(negedge clk);
      renable = 1'b0; wenable = 1'b0;
      checks++; if (L3_renable !== 1'b1 || L3_wenable !== 1'b1 || cache_stall !== 1'b1) begin errors++; $display("FAIL wr_req: l3en %b l3we %b stall %b want 1 1 1", L3_renable, L3_wenable, cache_stall); end
      checks++; if (L3_addr !== 32'h0000_8044 || L3_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_l3: addr %h wdata %h want 00008044 deadbeef", L3_addr, L3_wdata); end
      L3_stall = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (cache_stall !== 1'b0 || L3_renable !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL wr_done: stall %b l3en %b dv %b want 0 0 0", cache_stall, L3_renable, data_valid); end
      do_read(32'h0000_8040, '0, miss, d, ok);
      exp_line = line_of(8'h55);
      exp_line[32 +: 32] = 32'hDEAD_BEEF;
      checks++; if (miss !== 1'b0 || ok !== 1'b1) begin errors++; $display("FAIL wr_readback_hit: miss %b ok %b want 0 1", miss, ok); end
      checks++; if (d !== exp_line) begin errors++; $display("FAIL wr_readback_data: got %h want %h", d, exp_line); end
   endtask

   task automatic test_lru();
      logic miss, ok;
      logic [0:511] d;
      do_read(32'h0001_0000, blk_of(8'h11, 8'h12), miss, d, ok);
      checks++; if (miss !== 1'b1 || d !== line_of(8'h11)) begin errors++; $display("FAIL lru_A1: miss %b data %h want 1 all 11", miss, d); end
      do_read(32'h0002_0000, blk_of(8'h22, 8'h23), miss, d, ok);
      checks++; if (miss !== 1'b1 || d !== line_of(8'h22)) begin errors++; $display("FAIL lru_B1: miss %b data %h want 1 all 22", miss, d); end
      do_read(32'h0001_0000, '0, miss, d, ok);
      checks++; if (miss !== 1'b0 || d !== line_of(8'h11)) begin errors++; $display("FAIL lru_A2: miss %b data %h want 0 all 11", miss, d); end
      do_read(32'h0003_0000, blk_of(8'hCC, 8'hCD), miss, d, ok);
      checks++; if (miss !== 1'b1 || d !== line_of(8'hCC)) begin errors++; $display("FAIL lru_C: miss %b data %h want 1 all cc", miss, d); end
      do_read(32'h0001_0000, '0, miss, d, ok);
      checks++; if (miss !== 1'b0 || d !== line_of(8'h11)) begin errors++; $display("FAIL lru_A3: miss %b data %h want 0 all 11", miss, d); end
      do_read(32'h0002_0000, blk_of(8'h2A, 8'h2B), miss, d, ok);
      checks++; if (miss !== 1'b1 || ok !== 1'b1 || d !== line_of(8'h2A)) begin errors++; $display("FAIL lru_B2: miss %b ok %b data %h want 1 1 all 2a", miss, ok, d); end
   endtask

   task automatic test_write_miss();
      logic miss, ok;
      logic [0:511] d;
      @(negedge clk);
      renable = 1'b1; wenable = 1'b1; addr = 32'h0004_0080; wdata = 32'h1234_5678; L3_stall = 1'b0;
      @(posedge clk); @(negedge clk);
      renable = 1'b0; wenable = 1'b0;
      checks++; if (L3_addr !== 32'h0004_0080 || L3_wenable !== 1'b1) begin errors++; $display("FAIL wmiss_l3: addr %h we %b want 00040080 1", L3_addr, L3_wenable); end
      @(posedge clk); @(negedge clk);
      checks++; if (cache_stall !== 1'b0) begin errors++; $display("FAIL wmiss_done: stall %b want 0", cache_stall); end
      do_read(32'h0004_0080, blk_of(8'h33, 8'h44), miss, d, ok);
      checks++; if (miss !== 1'b1 || d !== line_of(8'h33)) begin errors++; $display("FAIL wmiss_noalloc: miss %b data %h want 1 all 33", miss, d); end
   endtask

   task automatic test_reset_mid();
      logic miss, ok;
      logic [0:511] d;
      int dv_cnt;
      @(negedge clk);
      renable = 1'b1; wenable = 1'b0; addr = 32'h0005_0000; L3_stall = 1'b1; L2_block = blk_of(8'h77, 8'h78);
      @(posedge clk); @(negedge clk);
      renable = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (cache_stall !== 1'b1 || L3_renable !== 1'b1) begin errors++; $display("FAIL rmid_pending: stall %b l3en %b want 1 1", cache_stall, L3_renable); end
      rst_n = 1'b0;
      #1;
      checks++; if (L3_renable !== 1'b0 || L3_wenable !== 1'b0 || cache_stall !== 1'b0) begin errors++; $display("FAIL rmid_async: l3en %b l3we %b stall %b want 0 0 0", L3_renable, L3_wenable, cache_stall); end
      L3_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      dv_cnt = 0;
      repeat (4) begin
         @(posedge clk); @(negedge clk);
         if (data_valid) dv_cnt++;
      end
      checks++; if (dv_cnt != 0) begin errors++; $display("FAIL rmid_no_dv: got %0d pulses want 0", dv_cnt); end
      do_read(32'h0004_0080, blk_of(8'h5A, 8'h5B), miss, d, ok);
      checks++; if (miss !== 1'b1 || ok !== 1'b1 || d !== line_of(8'h5A)) begin errors++; $display("FAIL rmid_lost_line: miss %b ok %b data %h want 1 1 all 5a", miss, ok, d); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_back_to_back();
      test_write_hit();
      test_lru();
      test_write_miss();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
